tff_bank_counter: RTL

- Parametrised successor to the single T flip-flop: a WIDTH-bit bank of T flip-flops with selectable operating mode.
  - Mode 0: independent per-bit toggle.
  - Mode 1: modulo-MOD up counter.
  - Mode 2: modulo-MOD down counter.
  - Mode 3: hold.
- Adds synchronous load, count enable, complementary outputs and a registered wrap pulse.
- Used as a general toggle/counter primitive for clock dividers and event counters in later blocks.

---
 rtl/tff_bank_counter_pkg.sv | 13 +
 rtl/tff_cell.sv | 30 +++
 rtl/tff_bank_counter.sv | 103 ++++++++++
 3 files changed

// File: rtl/tff_bank_counter_pkg.sv
// rtl/tff_bank_counter_pkg.sv - shared mode encoding for the T flip-flop bank counter
// Purpose: operating-mode constants used by tff_bank_counter and anything that drives its mode port.
// Ports:   none (package).
package tff_bank_counter_pkg;

   typedef enum logic [1:0] {
      MODE_TOGGLE = 2'd0,
      MODE_UP     = 2'd1,
      MODE_DOWN   = 2'd2,
      MODE_HOLD   = 2'd3
   } mode_t;

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with async active-low reset and synchronous load
// Purpose: one bit of the bank; toggles when t=1, takes d when load=1 (load wins).
// Ports:   clk  - rising-edge clock
//          rst  - asynchronous active-low reset, q returns to RST_VAL
//          t    - toggle request
//          load - synchronous load strobe
//          d    - load value
//          q    - flip-flop state
module tff_cell #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic t,
   input  logic load,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= RST_VAL;
      end else if (load) begin
         q <= d;
      end else if (t) begin
         q <= ~q;
      end
   end

endmodule

// File: rtl/tff_bank_counter.sv
// rtl/tff_bank_counter.sv - WIDTH-bit T flip-flop bank with toggle/up/down/hold modes
// Purpose: general toggle/counter primitive; modulo-MOD counting, synchronous load
//          (saturated to MOD-1), count enable, complementary outputs, registered wrap pulse.
// Ports:   clk   - rising-edge clock
//          rst   - asynchronous active-low reset
//          mode  - 0 toggle, 1 up, 2 down, 3 hold
//          en    - advance enable for modes 0-2
//          t_in  - per-bit toggle request (mode 0)
//          load  - synchronous load strobe, highest priority
//          d_in  - load value
//          q     - bank state
//          q_b   - bitwise complement of q
//          wrap  - one-cycle pulse after an edge on which the counter wrapped
module tff_bank_counter
   import tff_bank_counter_pkg::*;
#(
   parameter int unsigned     WIDTH   = 4,
   parameter longint unsigned MOD     = 64'd1 << WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             en,
   input  logic [WIDTH-1:0] t_in,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_b,
   output logic             wrap
);

   // One extra bit so that MOD = 2**WIDTH is representable in the compares.
   localparam logic [WIDTH:0]   MOD_W    = MOD[WIDTH:0];
   localparam logic [WIDTH:0]   MOD_M1   = MOD_W - (WIDTH+1)'(1);
   localparam logic [WIDTH-1:0] MOD_M1_Q = MOD_M1[WIDTH-1:0];

   logic [WIDTH:0]   q_ext;
   logic [WIDTH-1:0] d_sat;
   logic [WIDTH-1:0] next_q;
   logic [WIDTH-1:0] toggle_vec;
   logic             wrap_d;

   assign q_ext = {1'b0, q};
   assign d_sat = ({1'b0, d_in} < MOD_W) ? d_in : MOD_M1_Q;

   always_comb begin
      next_q = q;
      wrap_d = 1'b0;
      if (load) begin
         next_q = d_sat;
      end else if (en) begin
         case (mode_t'(mode))
            MODE_TOGGLE: next_q = q ^ t_in;
            MODE_UP: begin
               // >= rather than == so an out-of-range q left by mode 0 recovers to 0.
               if (q_ext >= MOD_M1) begin
                  next_q = '0;
                  wrap_d = 1'b1;
               end else begin
                  next_q = q + WIDTH'(1);
               end
            end
            MODE_DOWN: begin
               if (q == '0 || q_ext >= MOD_W) begin
                  next_q = MOD_M1_Q;
                  wrap_d = 1'b1;
               end else begin
                  next_q = q - WIDTH'(1);
               end
            end
            MODE_HOLD: next_q = q;
         endcase
      end
      // Every next-state choice is expressed as a toggle of the bits that change;
      // in mode 0 this reduces to t_in itself.
      toggle_vec = q ^ next_q;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell #(
         .RST_VAL (RST_VAL[i])
      ) u_cell (
         .clk  (clk),
         .rst  (rst),
         .t    (toggle_vec[i]),
         .load (load),
         .d    (d_sat[i]),
         .q    (q[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap <= 1'b0;
      end else begin
         wrap <= wrap_d;
      end
   end

   assign q_b = ~q;

endmodule
